// File: rtl/risc_debug_ctrl.sv
// risc_debug_ctrl: run/step/debug controller for the RISC_SPM core.
// It produces a single-cycle CPU clock-enable in the board clock domain.
// It also provides run-rate selection, debounced step and page keys, an
// enable-pulse counter and a paged register view for eight hex digits.
// Optional macro RISC_DBG_BREAKPOINT_EN adds the PC breakpoint, the BREAK
// state and the skip flag. Without it, BREAK is unreachable and brk_hit_o is 0.
module risc_debug_ctrl #(
    parameter int DATA_W          = 8,
    parameter int WORD_W          = 10,
    parameter int NUM_REGS        = 4,
    parameter int RUN_DIV         = 25000000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       run_sw_i,
    input  logic                       step_btn_i,
    input  logic                       page_btn_i,
    input  logic [1:0]                 div_sel_i,
    input  logic                       bp_arm_i,
    input  logic [DATA_W-1:0]          bp_addr_i,
    input  logic [DATA_W-1:0]          pc_i,
    input  logic [3:0]                 state_i,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat_i,
    output logic                       cpu_en_o,
    output logic [31:0]                digits_o,
    output logic [2:0]                 page_o,
    output logic                       halted_o,
    output logic                       brk_hit_o,
    output logic [CNT_W-1:0]           en_count_o
);

    localparam int DIV_W = $clog2(RUN_DIV);
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W:0]   RUN_DIV_V = (DIV_W + 1)'(RUN_DIV);
    localparam logic [2:0]       LAST_PAGE = 3'(NUM_REGS / 2 - 1);

    typedef enum logic [1:0] {ST_HALT, ST_RUN, ST_BREAK} state_t;

    state_t             state_q, state_d;
    logic               skip_q, skip_d;
    logic               cpuEn_q, cpuEn_d;
    logic [CNT_W-1:0]   enCount_q;
    logic [DIV_W-1:0]   divCnt_q;
    logic [DIV_W:0]     tcMinus1;
    logic               divReq;
    logic               bpMatch;
    logic               unusedSink;
    logic [2:0]         page_q;
    logic [31:0]        digits_q;

    // Button index 0 is the step key and index 1 is the page key.
    logic [1:0]         rawBtn;
    logic [1:0]         sync1_q, sync2_q, deb_q, debDel_q, pulse_q;
    logic [DB_W-1:0]    dbCnt_q [2];
    logic [7:0]         regByte [16];

    assign rawBtn = {page_btn_i, step_btn_i};

    // Two-flop synchronizer, stability counter and registered rising-edge pulse per key
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            debDel_q <= '0;
            pulse_q  <= '0;
            for (int b = 0; b < 2; b++) dbCnt_q[b] <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                sync1_q[b]  <= rawBtn[b];
                sync2_q[b]  <= sync1_q[b];
                debDel_q[b] <= deb_q[b];
                pulse_q[b]  <= deb_q[b] & ~debDel_q[b];
                if (sync2_q[b] == deb_q[b]) begin
                    dbCnt_q[b] <= '0;
                end else if (dbCnt_q[b] == DB_LAST) begin
                    deb_q[b]   <= sync2_q[b];
                    dbCnt_q[b] <= '0;
                end else begin
                    dbCnt_q[b] <= dbCnt_q[b] + DB_W'(1);
                end
            end
        end
    end

    // The terminal count follows div_sel at once, so a count already past it fires next
    assign tcMinus1 = (RUN_DIV_V >> div_sel_i) - (DIV_W + 1)'(1);
    assign divReq   = (state_q == ST_RUN) && ({1'b0, divCnt_q} >= tcMinus1);

`ifdef RISC_DBG_BREAKPOINT_EN
    assign bpMatch    = bp_arm_i && (pc_i == bp_addr_i) && !skip_q;
    assign unusedSink = (WORD_W < 0);
`else
    assign bpMatch    = 1'b0;
    assign unusedSink = (^{bp_arm_i, bp_addr_i, skip_q}) | (WORD_W < 0);
`endif

    // Divider runs only in RUN and wraps when it requests an enable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            divCnt_q <= '0;
        end else if (state_q != ST_RUN || divReq) begin
            divCnt_q <= '0;
        end else begin
            divCnt_q <= divCnt_q + DIV_W'(1);
        end
    end

    // FSM, skip flag and enable registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_HALT;
            skip_q    <= 1'b0;
            cpuEn_q   <= 1'b0;
            enCount_q <= '0;
        end else begin
            state_q   <= state_d;
            skip_q    <= skip_d;
            cpuEn_q   <= cpuEn_d;
            enCount_q <= enCount_q + CNT_W'(cpuEn_d);
        end
    end

    // Next state and enable decision; skip clears once the first enable of a run is issued
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        cpuEn_d = 1'b0;
        case (state_q)
            ST_HALT: begin
                cpuEn_d = pulse_q[0];
                if (run_sw_i) begin
                    state_d = ST_RUN;
                    skip_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (cpuEn_q) skip_d = 1'b0;
                cpuEn_d = divReq && !bpMatch;
                if (!run_sw_i)    state_d = ST_HALT;
                else if (bpMatch) state_d = ST_BREAK;
            end
            ST_BREAK: begin
                cpuEn_d = pulse_q[0];
                if (!run_sw_i) state_d = ST_HALT;
            end
            default: state_d = ST_HALT;
        endcase
        if (cpuEn_q) cpuEn_d = 1'b0;
    end

    // Display page advances on each page-key pulse in any state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            page_q <= '0;
        end else if (pulse_q[1]) begin
            page_q <= (page_q == LAST_PAGE) ? 3'd0 : page_q + 3'd1;
        end
    end

    // Low byte of each register, padded to 16 entries so {page,bit} indexes cleanly
    for (genvar g = 0; g < 16; g++) begin : gRegByte
        if (g < NUM_REGS) begin : gUsed
            assign regByte[g] = regs_flat_i[g*DATA_W +: 8];
        end else begin : gPad
            assign regByte[g] = 8'h00;
        end
    end

    // Registered digit image: PC, core state, page, then the selected register pair
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            digits_q <= '0;
        end else begin
            digits_q <= {pc_i[7:0], state_i, 1'b0, page_q,
                         regByte[{page_q, 1'b1}], regByte[{page_q, 1'b0}]};
        end
    end

    assign cpu_en_o   = cpuEn_q;
    assign en_count_o = enCount_q;
    assign page_o     = page_q;
    assign digits_o   = digits_q;
    assign halted_o   = (state_q != ST_RUN);
    assign brk_hit_o  = (state_q == ST_BREAK);

endmodule

// File: tb/tb_risc_debug_ctrl.sv
// Directed testbench for risc_debug_ctrl with short divider and debounce settings.
module tb_risc_debug_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run_sw, step_btn, page_btn, bp_arm;
    logic [1:0]  div_sel;
    logic [7:0]  bp_addr;
    logic [7:0]  pc = 8'h00;
    logic [3:0]  coreState;
    logic [31:0] regsFlat;
    logic        cpu_en, halted, brk_hit;
    logic [31:0] digits;
    logic [2:0]  page;
    logic [15:0] en_count;

    int compared = 0;
    int mismatched = 0;
    int enPulses = 0;
    int consecutive = 0;
    logic prevEn = 1'b0;
    logic pcAuto = 1'b0;

    risc_debug_ctrl #(
        .DATA_W(8), .WORD_W(10), .NUM_REGS(4), .RUN_DIV(16),
        .DEBOUNCE_CYCLES(4), .CNT_W(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .run_sw_i(run_sw), .step_btn_i(step_btn),
        .page_btn_i(page_btn), .div_sel_i(div_sel), .bp_arm_i(bp_arm),
        .bp_addr_i(bp_addr), .pc_i(pc), .state_i(coreState), .regs_flat_i(regsFlat),
        .cpu_en_o(cpu_en), .digits_o(digits), .page_o(page), .halted_o(halted),
        .brk_hit_o(brk_hit), .en_count_o(en_count)
    );

    always #5 clk = ~clk;

    // Core stand-in: the PC advances on each enable when enabled by the bench
    always @(posedge clk) begin
        if (pcAuto && cpu_en) pc <= pc + 8'd1;
    end

    // Pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (cpu_en) enPulses++;
        if (cpu_en && prevEn) consecutive++;
        prevEn = cpu_en;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic runSw, input logic [1:0] divSel,
                                 input logic arm, input logic [7:0] addr);
        run_sw  = runSw;
        div_sel = divSel;
        bp_arm  = arm;
        bp_addr = addr;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Cycles until cpu_en is seen high; bound+1 on timeout
    task automatic waitEn(input int bound, output int k);
        k = bound + 1;
        for (int i = 1; i <= bound; i++) begin
            @(posedge clk);
            #1;
            if (cpu_en) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic pressPage();
        page_btn = 1'b1;
        waitCycles(10);
        page_btn = 1'b0;
        waitCycles(10);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int base;
        int baseCount;
        rst_n = 1'b0;
        step_btn = 1'b0;
        page_btn = 1'b0;
        coreState = 4'hA;
        regsFlat = 32'h4433_2211;
        applyStimulus(1'b0, 2'd0, 1'b0, 8'h00);
        waitCycles(3);
        rst_n = 1'b1;

        // Reset and idle HALT
        base = enPulses;
        waitCycles(100);
        checkOutput("halt_no_en", enPulses - base, 0);
        checkOutput("halt_en_count", en_count, 0);
        checkOutput("halt_halted", halted, 1);
        checkOutput("halt_page", page, 0);
        checkOutput("halt_brk_hit", brk_hit, 0);
        checkOutput("digits_page0", digits, 32'h00A0_2211);

        // Paging
        pressPage();
        checkOutput("page_after_1", page, 1);
        checkOutput("digits_page1", digits, 32'h00A1_4433);
        pressPage();
        checkOutput("page_after_2", page, 0);
        checkOutput("digits_back0", digits[15:0], 16'h2211);

        // Run rate
        applyStimulus(1'b1, 2'd0, 1'b0, 8'h00);
        waitEn(100, k);
        checkOutput("run_first_latency", k, 17);
        waitEn(100, k);
        checkOutput("run_period_div0", k, 16);
        div_sel = 2'd2;
        waitEn(100, k);
        checkOutput("run_period_div2", k, 4);
        for (int p = 0; p < 7; p++) waitEn(20, k);
        checkOutput("run_en_count_10", en_count, 10);

        // Step key during RUN is ignored
        base = enPulses;
        step_btn = 1'b1;
        waitCycles(20);
        step_btn = 1'b0;
        waitCycles(20);
        checkOutput("run_step_ignored", enPulses - base, 10);

        run_sw = 1'b0;
        waitCycles(10);
        checkOutput("back_to_halt", halted, 1);

        // Debounced step in HALT with a leading glitch
        base = enPulses;
        baseCount = int'(en_count);
        step_btn = 1'b1;
        waitCycles(1);
        step_btn = 1'b0;
        waitCycles(4);
        step_btn = 1'b1;
        waitEn(50, k);
        checkOutput("step_latency", k, 8);
        waitCycles(12);
        step_btn = 1'b0;
        waitCycles(20);
        checkOutput("step_one_pulse", enPulses - base, 1);
        checkOutput("step_en_count", en_count, 16'(baseCount + 1));

`ifdef RISC_DBG_BREAKPOINT_EN
        // Breakpoint at PC 5, then resume through HALT
        pcAuto = 1'b1;
        applyStimulus(1'b1, 2'd2, 1'b1, 8'h05);
        k = 0;
        while (!brk_hit && k < 300) begin
            waitCycles(1);
            k++;
        end
        checkOutput("bp_hit", brk_hit, 1);
        checkOutput("bp_pc", pc, 8'h05);
        base = enPulses;
        waitCycles(40);
        checkOutput("bp_no_en", enPulses - base, 0);
        checkOutput("bp_still_break", brk_hit, 1);
        run_sw = 1'b0;
        waitCycles(3);
        run_sw = 1'b1;
        base = enPulses;
        k = 0;
        while (pc == 8'h05 && k < 60) begin
            waitCycles(1);
            k++;
        end
        checkOutput("resume_pc", pc, 8'h06);
        checkOutput("resume_one_en", enPulses - base, 1);
        waitCycles(20);
        checkOutput("resume_no_rebreak", brk_hit, 0);
        pcAuto = 1'b0;
        run_sw = 1'b0;
        waitCycles(5);
`endif

        // Asynchronous reset during an enable pulse
        applyStimulus(1'b1, 2'd2, 1'b0, 8'h00);
        waitEn(60, k);
        checkOutput("rst_saw_en", cpu_en, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_cpu_en", cpu_en, 0);
        checkOutput("rst_halted", halted, 1);
        checkOutput("rst_en_count", en_count, 0);
        run_sw = 1'b0;
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(5);

        checkOutput("never_back_to_back", consecutive, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
